// File: rtl/clock_pkg.sv
// clock_pkg: shared definitions for the clock time-setting path.
//   state_t            - sequencer state encoding (ST_RUN, ST_CLEAR, ST_SET)
//   FIELD_SEC/MIN/HOUR - counter field indices (field 0 is the cleared field)
//   DEFAULT_NUM_FIELDS - default number of counter fields
package clock_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_CLEAR = 2'd1,
        ST_SET   = 2'd2
    } state_t;

    localparam int FIELD_SEC  = 0;
    localparam int FIELD_MIN  = 1;
    localparam int FIELD_HOUR = 2;

    localparam int DEFAULT_NUM_FIELDS = 3;

endpackage

// File: rtl/set_sequencer_if.sv
// set_sequencer_if: button/timebase inputs and counter/display controls of the
// time-setting sequencer.
//   master modport - the sequencer (takes button pulses, drives controls)
//   slave modport  - the surrounding datapath (drives pulses, takes controls)
interface set_sequencer_if
    import clock_pkg::*;
#(
    parameter int NUM_FIELDS = DEFAULT_NUM_FIELDS
);
    logic                    i_Switch;
    logic                    i_Increment;
    logic                    i_Tick;
    logic                    o_Counters_Reset;
    logic                    o_Counters_Enable_Increment;
    logic [NUM_FIELDS-1:0]   o_Counters_Enable_Count;
    logic [NUM_FIELDS-2:0]   o_Display_Enable_Digits;
    logic                    o_Display_Enable_Dot;
    logic                    o_Display_Blank;
    logic                    o_Setting;

    modport master (
        input  i_Switch, i_Increment, i_Tick,
        output o_Counters_Reset, o_Counters_Enable_Increment,
               o_Counters_Enable_Count, o_Display_Enable_Digits,
               o_Display_Enable_Dot, o_Display_Blank, o_Setting
    );

    modport slave (
        output i_Switch, i_Increment, i_Tick,
        input  o_Counters_Reset, o_Counters_Enable_Increment,
               o_Counters_Enable_Count, o_Display_Enable_Digits,
               o_Display_Enable_Dot, o_Display_Blank, o_Setting
    );
endinterface

// File: rtl/idle_timeout.sv
// idle_timeout: saturating count of i_Tick strobes since the last i_Clear.
//   i_Clock  - clock
//   i_Reset  - synchronous active-high reset
//   i_Clear  - restart the idle count (activity); also suppresses expiry
//   i_Tick   - timebase strobe
//   o_Expire - one-cycle strobe on the tick that completes TIMEOUT_TICKS idle
//              ticks; TIMEOUT_TICKS = 0 never expires
module idle_timeout #(
    parameter int TIMEOUT_TICKS = 30
) (
    input  logic i_Clock,
    input  logic i_Reset,
    input  logic i_Clear,
    input  logic i_Tick,
    output logic o_Expire
);
    localparam int CNT_W = (TIMEOUT_TICKS > 0) ? $clog2(TIMEOUT_TICKS + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(TIMEOUT_TICKS);
    localparam logic [CNT_W-1:0] EXPIRE_AT = CNT_W'((TIMEOUT_TICKS > 0) ? TIMEOUT_TICKS - 1 : 0);
    localparam bit TIMEOUT_EN = (TIMEOUT_TICKS != 0);

    logic [CNT_W-1:0] r_Idle;

    // Left combinational so the sequencer can leave SET on the very edge
    // that samples the expiring tick.
    assign o_Expire = TIMEOUT_EN && i_Tick && !i_Clear && (r_Idle == EXPIRE_AT);

    // Idle tick counter: cleared by activity, saturates at TIMEOUT_TICKS.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_Idle <= {CNT_W{1'b0}};
        end else if (i_Clear) begin
            r_Idle <= {CNT_W{1'b0}};
        end else if (i_Tick && (r_Idle != CNT_MAX)) begin
            r_Idle <= r_Idle + CNT_W'(1);
        end else begin
            r_Idle <= r_Idle;
        end
    end
endmodule

// File: rtl/set_sequencer.sv
// set_sequencer: time-setting mode sequencer for the clock.
// Steps RUN -> (CLEAR) -> SET 1 .. SET NUM_FIELDS-1 -> RUN on i_Switch pulses,
// blinks the field being set and falls back to RUN after an idle timeout.
//   i_Clock, i_Reset - clock and synchronous active-high reset
//   bus (master)     - i_Switch/i_Increment/i_Tick pulses in; counter enables,
//                      digit selects, dot, blank and o_Setting out
// All outputs are registered decodes of the next state, so an input sampled at
// an edge shows on the outputs right after that edge.
module set_sequencer
    import clock_pkg::*;
#(
    parameter int NUM_FIELDS    = DEFAULT_NUM_FIELDS,
    parameter int TIMEOUT_TICKS = 30,
    parameter int CLEAR_ON_SET  = 1
) (
    input  logic             i_Clock,
    input  logic             i_Reset,
    set_sequencer_if.master  bus
);
    localparam int FIELD_W = $clog2(NUM_FIELDS);
    localparam int DIG_W   = NUM_FIELDS - 1;
    localparam logic [FIELD_W-1:0] FIRST_FIELD = FIELD_W'(FIELD_MIN);
    localparam logic [FIELD_W-1:0] LAST_FIELD  = FIELD_W'(NUM_FIELDS - 1);

    state_t               r_State;
    logic [FIELD_W-1:0]   r_Field;
    logic                 r_Blink;

    state_t               next_state_s;
    logic [FIELD_W-1:0]   next_field_s;
    logic                 next_blink_s;
    logic                 idle_clear_s;
    logic                 expire_s;

    logic                 nx_reset_s, nx_inc_s, nx_dot_s, nx_blank_s, nx_setting_s;
    logic [NUM_FIELDS-1:0] nx_count_s;
    logic [DIG_W-1:0]     nx_digits_s;

    logic                 reset_r, inc_r, dot_r, blank_r, setting_r;
    logic [NUM_FIELDS-1:0] count_r;
    logic [DIG_W-1:0]     digits_r;

    // Leaving CLEAR always enters SET 1, so that cycle restarts the idle count
    // just like an explicit switch or increment does.
    assign idle_clear_s = bus.i_Switch || bus.i_Increment || (r_State == ST_CLEAR);

    idle_timeout #(
        .TIMEOUT_TICKS (TIMEOUT_TICKS)
    ) u_idle_timeout (
        .i_Clock  (i_Clock),
        .i_Reset  (i_Reset),
        .i_Clear  (idle_clear_s),
        .i_Tick   (bus.i_Tick),
        .o_Expire (expire_s)
    );

    // Next state and field; a switch in SET takes priority over a timeout.
    always_comb begin
        next_state_s = r_State;
        next_field_s = r_Field;
        case (r_State)
            ST_RUN: begin
                if (bus.i_Switch) begin
                    if (CLEAR_ON_SET != 0) begin
                        next_state_s = ST_CLEAR;
                    end else begin
                        next_state_s = ST_SET;
                        next_field_s = FIRST_FIELD;
                    end
                end else begin
                    next_state_s = ST_RUN;
                end
            end
            ST_CLEAR: begin
                next_state_s = ST_SET;
                next_field_s = FIRST_FIELD;
            end
            ST_SET: begin
                if (bus.i_Switch) begin
                    if (r_Field == LAST_FIELD) begin
                        next_state_s = ST_RUN;
                        next_field_s = FIRST_FIELD;
                    end else begin
                        next_field_s = r_Field + FIELD_W'(1);
                    end
                end else if (expire_s) begin
                    next_state_s = ST_RUN;
                    next_field_s = FIRST_FIELD;
                end else begin
                    next_state_s = ST_SET;
                end
            end
            default: begin
                next_state_s = ST_RUN;
                next_field_s = FIRST_FIELD;
            end
        endcase
    end

    // Blink phase: restarts dark-off on field entry and on increment.
    always_comb begin
        if (next_state_s != ST_SET) begin
            next_blink_s = 1'b0;
        end else if ((r_State != ST_SET) || bus.i_Switch) begin
            next_blink_s = 1'b0;
        end else if (bus.i_Increment) begin
            next_blink_s = 1'b0;
        end else if (bus.i_Tick) begin
            next_blink_s = ~r_Blink;
        end else begin
            next_blink_s = r_Blink;
        end
    end

    // Output decode of the next state, registered below.
    always_comb begin
        nx_reset_s   = 1'b0;
        nx_inc_s     = 1'b0;
        nx_count_s   = {NUM_FIELDS{1'b1}};
        nx_digits_s  = {DIG_W{1'b0}};
        nx_dot_s     = 1'b1;
        nx_blank_s   = 1'b0;
        nx_setting_s = 1'b0;
        case (next_state_s)
            ST_RUN: begin
                nx_count_s = {NUM_FIELDS{1'b1}};
                nx_dot_s   = 1'b1;
            end
            ST_CLEAR: begin
                nx_reset_s   = 1'b1;
                nx_count_s   = {NUM_FIELDS{1'b0}};
                nx_dot_s     = 1'b0;
                nx_setting_s = 1'b1;
            end
            ST_SET: begin
                nx_inc_s     = 1'b1;
                nx_count_s   = NUM_FIELDS'(1'b1) << next_field_s;
                nx_digits_s  = DIG_W'(1'b1) << (next_field_s - FIRST_FIELD);
                nx_dot_s     = 1'b0;
                nx_blank_s   = next_blink_s;
                nx_setting_s = 1'b1;
            end
            default: begin
                nx_count_s = {NUM_FIELDS{1'b1}};
                nx_dot_s   = 1'b1;
            end
        endcase
    end

    // State, blink and output registers; reset lands in the RUN decode.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_State   <= ST_RUN;
            r_Field   <= FIRST_FIELD;
            r_Blink   <= 1'b0;
            reset_r   <= 1'b0;
            inc_r     <= 1'b0;
            count_r   <= {NUM_FIELDS{1'b1}};
            digits_r  <= {DIG_W{1'b0}};
            dot_r     <= 1'b1;
            blank_r   <= 1'b0;
            setting_r <= 1'b0;
        end else begin
            r_State   <= next_state_s;
            r_Field   <= next_field_s;
            r_Blink   <= next_blink_s;
            reset_r   <= nx_reset_s;
            inc_r     <= nx_inc_s;
            count_r   <= nx_count_s;
            digits_r  <= nx_digits_s;
            dot_r     <= nx_dot_s;
            blank_r   <= nx_blank_s;
            setting_r <= nx_setting_s;
        end
    end

    assign bus.o_Counters_Reset            = reset_r;
    assign bus.o_Counters_Enable_Increment = inc_r;
    assign bus.o_Counters_Enable_Count     = count_r;
    assign bus.o_Display_Enable_Digits     = digits_r;
    assign bus.o_Display_Enable_Dot        = dot_r;
    assign bus.o_Display_Blank             = blank_r;
    assign bus.o_Setting                   = setting_r;
endmodule
